// File: rtl/disk_pkg.sv
// disk_pkg: shared state encoding and disk geometry helper for the block engine.
`default_nettype none

package disk_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    XFER   = 3'd2,
    PAD    = 3'd3,
    DRAIN  = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Linear block address; callers truncate the 32-bit result to their LBA width.
  function automatic logic [31:0] geom_lba(input logic [31:0] cyl, input logic [31:0] sur,
                                           input logic [31:0] sec, input logic [31:0] sectors,
                                           input logic [31:0] surfaces);
    return sec + sectors * (sur + surfaces * cyl);
  endfunction

endpackage

`default_nettype wire

// File: rtl/disk_addr_counter.sv
// disk_addr_counter: cylinder/surface/sector register with load, advance, LBA and overrun.
`default_nettype none

module disk_addr_counter
  import disk_pkg::*;
#(
  parameter int CYL_W     = 8,
  parameter int CYLINDERS = 203,
  parameter int SURFACES  = 2,
  parameter int SECTORS   = 12,
  parameter int SEC_W     = 4,
  parameter int LBA_W     = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_advance,
  input  logic [CYL_W-1:0] i_cyl,
  input  logic             i_sur,
  input  logic [SEC_W-1:0] i_sec,
  output logic [CYL_W-1:0] o_cyl,
  output logic             o_sur,
  output logic [SEC_W-1:0] o_sec,
  output logic [LBA_W-1:0] o_lba,
  output logic             o_ovr
);

  localparam logic [31:0] c_CYLINDERS = CYLINDERS;
  localparam logic [31:0] c_SURFACES  = SURFACES;
  localparam logic [31:0] c_SECTORS   = SECTORS;

  logic [CYL_W-1:0] r_cyl;
  logic             r_sur;
  logic [SEC_W-1:0] r_sec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyl <= '0;
      r_sur <= 1'b0;
      r_sec <= '0;
    end else if (i_load) begin
      r_cyl <= i_cyl;
      r_sur <= i_sur;
      r_sec <= i_sec;
    end else if (i_advance) begin
      // Ripple sector -> surface -> cylinder; the cylinder is left to run past the end
      // so the next issue attempt reports the overrun.
      if (32'(r_sec) + 32'd1 >= c_SECTORS) begin
        r_sec <= '0;
        if (32'(r_sur) + 32'd1 >= c_SURFACES) begin
          r_sur <= 1'b0;
          r_cyl <= r_cyl + 1'b1;
        end else begin
          r_sur <= r_sur + 1'b1;
        end
      end else begin
        r_sec <= r_sec + 1'b1;
      end
    end
  end

  assign o_cyl = r_cyl;
  assign o_sur = r_sur;
  assign o_sec = r_sec;
  assign o_lba = LBA_W'(geom_lba(32'(r_cyl), 32'(r_sur), 32'(r_sec), c_SECTORS, c_SURFACES));
  assign o_ovr = (32'(r_cyl) >= c_CYLINDERS);

endmodule

`default_nettype wire

// File: rtl/disk_block_engine.sv
// disk_block_engine: word-counted DMA sequencer issuing one storage command per disk block.
`default_nettype none

module disk_block_engine
  import disk_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int CYL_W       = 8,
  parameter int CYLINDERS   = 203,
  parameter int SURFACES    = 2,
  parameter int SECTORS     = 12,
  parameter int SEC_W       = 4,
  parameter int LBA_W       = 13,
  parameter int BLOCK_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dir,
  input  logic              inh_ba,
  input  logic [15:0]       wc_neg,
  input  logic [ADDR_W-2:0] ba_start,
  input  logic [CYL_W-1:0]  cyl_in,
  input  logic              sur_in,
  input  logic [SEC_W-1:0]  sec_in,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err_nxm,
  output logic              err_ovr,
  output logic [ADDR_W-2:0] ba,
  output logic [15:0]       wc,
  output logic [CYL_W-1:0]  cyl,
  output logic              sur,
  output logic [SEC_W-1:0]  sec,
  output logic              dma_read_req,
  output logic              dma_write_req,
  input  logic              dma_complete,
  input  logic              dma_nxm,
  output logic [LBA_W-1:0]  sd_lba,
  output logic              sd_read,
  output logic              sd_write,
  input  logic              sd_ready,
  output logic              sd_write_enable,
  output logic              sd_pad,
  input  logic              sd_write_full,
  output logic              sd_read_enable,
  input  logic              sd_read_empty
);

  localparam int          WPOS_W      = $clog2(BLOCK_WORDS);
  localparam logic [31:0] c_CYLINDERS = CYLINDERS;
  localparam logic [31:0] c_SECTORS   = SECTORS;

  state_t              r_state;
  logic                r_dir;
  logic                r_inh;
  logic [15:0]         r_wc;
  logic [ADDR_W-2:0]   r_ba;
  logic [WPOS_W-1:0]   r_wpos;
  logic                r_pend;
  logic                r_busy;
  logic                r_done;
  logic                r_err_nxm;
  logic                r_err_ovr;
  logic                r_sd_read;
  logic                r_sd_write;
  logic [LBA_W-1:0]    r_sd_lba;

  logic                w_load;
  logic                w_issue;
  logic                w_ovr;
  logic [LBA_W-1:0]    w_lba;
  logic                w_bad_start;
  logic                w_last_word;
  logic                w_wc_last;
  logic                w_pad_push;
  logic                w_drain_pop;

  assign w_load      = (r_state == IDLE) && start && !abort;
  assign w_issue     = (r_state == ISSUE) && !abort && !w_ovr && sd_ready;
  assign w_bad_start = (32'(sec_in) >= c_SECTORS) || (32'(cyl_in) >= c_CYLINDERS);
  assign w_last_word = (r_wpos == '1);
  assign w_wc_last   = (r_wc == 16'hFFFF);
  // A pending DMA-word push/pop owns the FIFO port for its cycle, so fill/drain waits.
  assign w_pad_push  = (r_state == PAD) && !sd_write_full && !r_pend;
  assign w_drain_pop = (r_state == DRAIN) && !sd_read_empty && !r_pend;

  disk_addr_counter #(
    .CYL_W    (CYL_W),
    .CYLINDERS(CYLINDERS),
    .SURFACES (SURFACES),
    .SECTORS  (SECTORS),
    .SEC_W    (SEC_W),
    .LBA_W    (LBA_W)
  ) u_addr (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_advance(w_issue),
    .i_cyl    (cyl_in),
    .i_sur    (sur_in),
    .i_sec    (sec_in),
    .o_cyl    (cyl),
    .o_sur    (sur),
    .o_sec    (sec),
    .o_lba    (w_lba),
    .o_ovr    (w_ovr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_dir      <= 1'b0;
      r_inh      <= 1'b0;
      r_wc       <= '0;
      r_ba       <= '0;
      r_wpos     <= '0;
      r_pend     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_nxm  <= 1'b0;
      r_err_ovr  <= 1'b0;
      r_sd_read  <= 1'b0;
      r_sd_write <= 1'b0;
      r_sd_lba   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_sd_read  <= 1'b0;
      r_sd_write <= 1'b0;
      r_pend     <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_dir     <= dir;
              r_inh     <= inh_ba;
              r_wc      <= wc_neg;
              r_ba      <= ba_start;
              r_wpos    <= '0;
              r_err_nxm <= 1'b0;
              r_err_ovr <= 1'b0;
              if (wc_neg == 16'h0000) begin
                r_done <= 1'b1;
              end else if (w_bad_start) begin
                r_err_ovr <= 1'b1;
                r_done    <= 1'b1;
              end else begin
                r_busy  <= 1'b1;
                r_state <= dir ? ISSUE : XFER;
              end
            end
          end
          ISSUE: begin
            if (w_ovr) begin
              r_err_ovr <= 1'b1;
              r_state   <= FINISH;
            end else if (sd_ready) begin
              r_sd_read  <= r_dir;
              r_sd_write <= !r_dir;
              r_sd_lba   <= w_lba;
              r_state    <= (r_dir || r_wc != 16'h0000) ? XFER : FINISH;
            end
          end
          XFER: begin
            if (dma_nxm) begin
              r_err_nxm <= 1'b1;
              r_state   <= FINISH;
            end else if (dma_complete) begin
              r_wc   <= r_wc + 1'b1;
              r_wpos <= r_wpos + 1'b1;
              r_pend <= 1'b1;
              if (!r_inh) r_ba <= r_ba + 1'b1;
              if (w_last_word) r_state <= (!r_dir || !w_wc_last) ? ISSUE : FINISH;
              else if (w_wc_last) r_state <= r_dir ? DRAIN : PAD;
            end
          end
          PAD: begin
            if (w_pad_push) begin
              r_wpos <= r_wpos + 1'b1;
              if (w_last_word) r_state <= ISSUE;
            end
          end
          DRAIN: begin
            if (w_drain_pop) begin
              r_wpos <= r_wpos + 1'b1;
              if (w_last_word) r_state <= FINISH;
            end
          end
          FINISH: begin
            // Hold off while a command pulse is still in flight so sd_ready reflects it.
            if (sd_ready && !r_sd_read && !r_sd_write) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign err_nxm         = r_err_nxm;
  assign err_ovr         = r_err_ovr;
  assign ba              = r_ba;
  assign wc              = r_wc;
  assign sd_lba          = r_sd_lba;
  assign sd_read         = r_sd_read;
  assign sd_write        = r_sd_write;
  assign dma_read_req    = (r_state == XFER) && !r_dir && !sd_write_full && !r_pend && (r_wc != 16'h0000);
  assign dma_write_req   = (r_state == XFER) && r_dir && !sd_read_empty && !r_pend && (r_wc != 16'h0000);
  assign sd_write_enable = (r_pend && !r_dir) || w_pad_push;
  assign sd_pad          = w_pad_push;
  assign sd_read_enable  = (r_pend && r_dir) || w_drain_pop;

endmodule

`default_nettype wire

// File: tb/tb_disk_block_engine.sv
// tb_disk_block_engine: directed vectors against disk_block_engine with DMA and storage models.
`default_nettype none

module tb_disk_block_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic        inh_ba = 1'b0;
  logic [15:0] wc_neg = '0;
  logic [20:0] ba_start = '0;
  logic [7:0]  cyl_in = '0;
  logic        sur_in = 1'b0;
  logic [3:0]  sec_in = '0;
  logic        abort = 1'b0;
  logic        busy, done, err_nxm, err_ovr;
  logic [20:0] ba;
  logic [15:0] wc;
  logic [7:0]  cyl;
  logic        sur;
  logic [3:0]  sec;
  logic        dma_read_req, dma_write_req;
  logic        dma_complete = 1'b0;
  logic        dma_nxm = 1'b0;
  logic [12:0] sd_lba;
  logic        sd_read, sd_write;
  logic        sd_ready = 1'b1;
  logic        sd_write_enable, sd_pad;
  logic        sd_write_full = 1'b0;
  logic        sd_read_enable;
  logic        sd_read_empty = 1'b0;

  disk_block_engine #(.CYLINDERS(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dir(dir), .inh_ba(inh_ba),
    .wc_neg(wc_neg), .ba_start(ba_start), .cyl_in(cyl_in), .sur_in(sur_in), .sec_in(sec_in),
    .abort(abort), .busy(busy), .done(done), .err_nxm(err_nxm), .err_ovr(err_ovr),
    .ba(ba), .wc(wc), .cyl(cyl), .sur(sur), .sec(sec),
    .dma_read_req(dma_read_req), .dma_write_req(dma_write_req),
    .dma_complete(dma_complete), .dma_nxm(dma_nxm),
    .sd_lba(sd_lba), .sd_read(sd_read), .sd_write(sd_write), .sd_ready(sd_ready),
    .sd_write_enable(sd_write_enable), .sd_pad(sd_pad), .sd_write_full(sd_write_full),
    .sd_read_enable(sd_read_enable), .sd_read_empty(sd_read_empty)
  );

  always #25 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_push = 0, n_pad = 0, n_pop = 0, n_dma = 0, n_nxm = 0, n_done = 0, n_rd = 0, n_wr = 0;
  int st_cnt = 0;
  int nxm_at = -1;
  bit throttle = 1'b0;
  logic [12:0] lba_q[$];

  int b_push, b_pad, b_pop, b_dma, b_done, b_rd, b_wr, b_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Storage and DMA responders plus event counters, all sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sd_write_enable) n_push++;
      if (sd_pad) n_pad++;
      if (sd_read_enable) n_pop++;
      if (done) n_done++;
      if (sd_read || sd_write) begin
        lba_q.push_back(sd_lba);
        if (sd_read) n_rd++;
        else n_wr++;
        st_cnt = 4;
        sd_ready = 1'b0;
      end else if (st_cnt > 0) begin
        st_cnt--;
        if (st_cnt == 0) sd_ready = 1'b1;
      end
      if (dma_complete || dma_nxm) begin
        dma_complete = 1'b0;
        dma_nxm = 1'b0;
      end else if (reset_n && (dma_read_req || dma_write_req)) begin
        if (n_dma + n_nxm + 1 == nxm_at) begin
          dma_nxm = 1'b1;
          n_nxm++;
        end else begin
          dma_complete = 1'b1;
          n_dma++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      sd_write_full = throttle && ($urandom_range(0, 3) == 0);
      sd_read_empty = throttle && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic snap();
    b_push = n_push; b_pad = n_pad; b_pop = n_pop; b_dma = n_dma;
    b_done = n_done; b_rd = n_rd; b_wr = n_wr; b_q = lba_q.size();
  endtask

  task automatic kick(input bit d, input bit inh, input logic [15:0] w, input logic [20:0] b,
                      input logic [7:0] c, input logic s, input logic [3:0] sc);
    snap();
    @(negedge clk);
    dir = d; inh_ba = inh; wc_neg = w; ba_start = b; cyl_in = c; sur_in = s; sec_in = sc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 6000 && n_done == b_done; i++) @(negedge clk);
    check({tag, "_done_seen"}, 64'(n_done != b_done), 64'd1);
    repeat (10) @(negedge clk);
    check({tag, "_done_cnt"}, 64'(n_done - b_done), 64'd1);
  endtask

  task automatic wait_dmas(input int n);
    for (int i = 0; i < 2000 && n_dma - b_dma < n; i++) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ba", 64'(ba), 64'd0);
    check("rst_wc", 64'(wc), 64'd0);
    check("rst_misc", {busy, done, err_nxm, err_ovr, cyl, sur, sec, dma_read_req, dma_write_req,
                       sd_lba, sd_read, sd_write, sd_write_enable, sd_pad, sd_read_enable}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two-block write
    kick(1'b0, 1'b0, 16'hFE00, 21'h800, 8'd0, 1'b0, 4'd0);
    wait_done("t1");
    check("t1_push", 64'(n_push - b_push), 64'd512);
    check("t1_pad", 64'(n_pad - b_pad), 64'd0);
    check("t1_nwr", 64'(n_wr - b_wr), 64'd2);
    check("t1_lba0", 64'(lba_q[b_q]), 64'd0);
    check("t1_lba1", 64'(lba_q[b_q+1]), 64'd1);
    check("t1_ba", 64'(ba), 64'hA00);
    check("t1_sec", 64'(sec), 64'd2);
    check("t1_wc_busy", {wc, 7'd0, busy}, 64'd0);

    // 2: short read from the last sector of a track, FIFOs throttled
    throttle = 1'b1;
    kick(1'b1, 1'b0, 16'hFF9C, 21'h0, 8'd0, 1'b0, 4'd11);
    wait_done("t2");
    check("t2_nrd", 64'(n_rd - b_rd), 64'd1);
    check("t2_lba", 64'(lba_q[b_q]), 64'd11);
    check("t2_dma", 64'(n_dma - b_dma), 64'd100);
    check("t2_pops", 64'(n_pop - b_pop), 64'd256);
    check("t2_addr", {cyl, 3'd0, sur, sec}, {8'd0, 3'd0, 1'b1, 4'd0});

    // 3: partial write padded to a block; a start mid-transfer must be ignored
    kick(1'b0, 1'b0, 16'hFFF6, 21'h40, 8'd0, 1'b0, 4'd0);
    repeat (6) @(negedge clk);
    dir = 1'b1; wc_neg = 16'hFFFF; sec_in = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3");
    check("t3_push", 64'(n_push - b_push), 64'd256);
    check("t3_pad", 64'(n_pad - b_pad), 64'd246);
    check("t3_nwr_nrd", {32'(n_wr - b_wr), 32'(n_rd - b_rd)}, {32'd1, 32'd0});
    check("t3_lba", 64'(lba_q[b_q]), 64'd0);
    check("t3_ba", 64'(ba), 64'h4A);
    throttle = 1'b0;

    // 4: inhibited bus address, 300-word read
    kick(1'b1, 1'b1, 16'hFED4, 21'h123, 8'd0, 1'b0, 4'd0);
    wait_done("t4");
    check("t4_ba", 64'(ba), 64'h123);
    check("t4_nrd", 64'(n_rd - b_rd), 64'd2);
    check("t4_lba0", 64'(lba_q[b_q]), 64'd0);
    check("t4_lba1", 64'(lba_q[b_q+1]), 64'd1);
    check("t4_wc", 64'(wc), 64'd0);
    check("t4_pops", 64'(n_pop - b_pop), 64'd512);

    // 5: NXM on the third DMA of a one-block write
    nxm_at = n_dma + n_nxm + 3;
    kick(1'b0, 1'b0, 16'hFF00, 21'h0, 8'd0, 1'b0, 4'd0);
    wait_done("t5");
    nxm_at = -1;
    check("t5_nxm", 64'(err_nxm), 64'd1);
    check("t5_wc", 64'(wc), 64'hFF02);
    check("t5_ba", 64'(ba), 64'd2);
    check("t5_nwr", 64'(n_wr - b_wr), 64'd0);
    check("t5_push", 64'(n_push - b_push), 64'd2);

    // 6: read running off the last cylinder
    kick(1'b1, 1'b0, 16'hFE00, 21'h0, 8'd1, 1'b1, 4'd11);
    wait_done("t6");
    check("t6_nrd", 64'(n_rd - b_rd), 64'd1);
    check("t6_lba", 64'(lba_q[b_q]), 64'd47);
    check("t6_dma", 64'(n_dma - b_dma), 64'd256);
    check("t6_flags", {err_ovr, err_nxm}, 64'b10);
    check("t6_cyl", 64'(cyl), 64'd2);

    // zero word count completes without commands
    kick(1'b1, 1'b0, 16'h0000, 21'h0, 8'd0, 1'b0, 4'd0);
    wait_done("wc0");
    check("wc0_cmds", 64'(n_rd + n_wr - b_rd - b_wr), 64'd0);
    check("wc0_err", {err_ovr, err_nxm, busy}, 64'd0);

    // out-of-range starting sector
    kick(1'b0, 1'b0, 16'hFFF0, 21'h0, 8'd0, 1'b0, 4'd12);
    wait_done("badsec");
    check("badsec_ovr", 64'(err_ovr), 64'd1);
    check("badsec_cmds", 64'(n_rd + n_wr + n_dma - b_rd - b_wr - b_dma), 64'd0);

    // synchronous abort mid-transfer
    kick(1'b0, 1'b0, 16'hFF00, 21'h0, 8'd0, 1'b0, 4'd0);
    wait_dmas(5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {busy, dma_read_req, sd_write_enable}, 64'd0);
    check("abort_keep_ovr", 64'(err_ovr), 64'd0);
    repeat (30) @(negedge clk);
    check("abort_nodone", 64'(n_done - b_done), 64'd0);
    check("abort_nwr", 64'(n_wr - b_wr), 64'd0);

    // asynchronous reset mid-transfer
    kick(1'b0, 1'b0, 16'hFE00, 21'h300, 8'd0, 1'b0, 4'd3);
    wait_dmas(7);
    check("arst_prebusy", 64'(busy), 64'd1);
    #5 reset_n = 1'b0;
    #1;
    check("arst_ba_wc", {ba, wc}, 64'd0);
    check("arst_misc", {busy, done, err_nxm, err_ovr, cyl, sur, sec, dma_read_req, dma_write_req,
                        sd_lba, sd_read, sd_write, sd_write_enable, sd_pad, sd_read_enable}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/disk_block_engine.md
Name: disk_block_engine

Overview:
- Parametrised DMA/block sequencer: the transfer core for the RKV11 successor and for later disk controllers such as the RLV12.
- Moves a word-counted DMA transfer between the QBUS DMA handshake and the storage-device FIFOs, and issues one storage read/write command per disk block.
- Generalises disk geometry, block size and bus-address width over the current RKV11.
- Adds behaviour the RKV11 lacks: partial-block padding/draining, disk-address overrun detection, NXM abort and a synchronous abort.
- The register file (RKCS/RKWC/…) stays in the controller and drives this block through start/parameter ports.

Parameters:
ADDR_W, 22, bus address width; word address is ba[ADDR_W-1:1]
CYL_W, 8, cylinder field width
CYLINDERS, 203, number of cylinders
SURFACES, 2, surfaces per cylinder
SECTORS, 12, sectors per track
SEC_W, 4, sector field width
LBA_W, 13, linear block address width
BLOCK_WORDS, 256, 16-bit words per block (power of 2)

Ports:
clk  in  1  system clock (20 MHz)
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
dir  in  1  1 = disk read (DMA to memory), 0 = disk write
inh_ba  in  1  inhibit bus-address increment
wc_neg  in  16  two's-complement negative word count
ba_start  in  ADDR_W-1  starting word address
cyl_in / sur_in / sec_in  in  CYL_W / 1 / SEC_W  starting disk address
abort  in  1  synchronous cancel (controller reset)
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
err_nxm / err_ovr  out  1 / 1  sticky until next accepted start
ba  out  ADDR_W-1  current word address; TAL = {ba,1'b0}
wc  out  16  current word count
cyl / sur / sec  out  CYL_W / 1 / SEC_W  current disk address
dma_read_req / dma_write_req  out  1 / 1  DMA requests
dma_complete / dma_nxm  in  1 / 1  DMA handshake responses
sd_lba  out  LBA_W  block address for sd_read/sd_write
sd_read / sd_write  out  1 / 1  one-cycle command pulses
sd_ready  in  1  storage idle, accepts a command
sd_write_enable / sd_pad  out  1 / 1  write-FIFO push; sd_pad = push zero
sd_write_full  in  1
sd_read_enable  out  1  read-FIFO pop (first-word-fall-through)
sd_read_empty  in  1

Behaviour:
Reset and abort
- Reset: all outputs 0, state IDLE, internal counters 0.
- abort has priority over everything except reset: next cycle → IDLE, requests/pulses low, no done; error flags keep their values.

Start (IDLE)
- On start, latch all inputs; clear err flags; wpos (word-in-block, log2 BLOCK_WORDS bits) ← 0; busy ← 1.
- If wc_neg==0: done one cycle later, no commands.
- If sec_in>=SECTORS or cyl_in>=CYLINDERS: err_ovr, done, no commands.
- Otherwise next state: ISSUE if dir=1, XFER if dir=0.

lba and address advance
- lba = sec + SECTORS*(sur + SURFACES*cyl), truncated to LBA_W.
- Advance after every issued command: sec+1; sec==SECTORS → sec=0, sur+1; sur==SURFACES → sur=0, cyl+1.

States
- ISSUE: if cyl>=CYLINDERS → err_ovr, go FINISH. Else wait sd_ready, then pulse sd_read/sd_write with sd_lba=lba and advance the address. Next: dir=1 → XFER; dir=0 → XFER if wc!=0, else FINISH.
- XFER, write direction: dma_read_req = !sd_write_full & !push_pend & wc!=0.
- XFER, read direction: dma_write_req = !sd_read_empty & !pop_pend & wc!=0.
- Each dma_complete:
  - wc+1;
  - ba+1 unless inh_ba (wraps modulo 2^(ADDR_W-1));
  - wpos+1;
  - set pend.
- Pend handling: the cycle after dma_complete, sd_write_enable (write) or sd_read_enable (read) pulses and pend clears.
- Block boundary (wpos wraps to 0): write → ISSUE; read → ISSUE if wc!=0, else FINISH.
- wc reaches 0 with wpos!=0: write → PAD; read → DRAIN.
- PAD: sd_write_enable=sd_pad=1 each cycle !sd_write_full until wpos wraps, then ISSUE.
- DRAIN: sd_read_enable each cycle !sd_read_empty until wpos wraps, then FINISH.
- FINISH: wait sd_ready, pulse done, busy←0, IDLE.

Error and simultaneous events
- dma_nxm in XFER → err_nxm; no pad/drain; no further command; go FINISH. wc/ba are not advanced for the failing cycle.
- dma_complete and dma_nxm in the same cycle: NXM wins.
- start while busy: ignored.

Decomposition:
- Package disk_pkg: state enum (IDLE, ISSUE, XFER, PAD, DRAIN, FINISH); function geom_lba(cyl,sur,sec).
- Sub-module disk_addr_counter: holds cyl/sur/sec, load, advance, lba and overrun outputs.

Test Plan:
Test configuration: BLOCK_WORDS=256, SECTORS=12, SURFACES=2, CYLINDERS=2.
1. Write, wc_neg=16'hFE00, ba_start=0x800, disk 0/0/0 → 512 pushes; sd_write lba 0 then 1; ba=0xA00; sec=2; one done.
2. Read, wc_neg=16'hFF9C, disk 0/0/11 → sd_read lba 11; 100 DMA; 156 drain pops; sur=1, sec=0 at done.
3. Write 10 words → 10 data pushes + 246 sd_pad pushes, one sd_write lba 0.
4. inh_ba=1, 300-word read → ba constant; sd_read lba 0,1; wc=0.
5. Write 256 words, dma_nxm on 3rd DMA → err_nxm; wc=16'hFF02; no sd_write; done.
6. Read 512 words from 1/1/11 → sd_read lba 47, 256 DMAs, then err_ovr, done. Separately, assert reset_n low mid-XFER → all outputs 0 immediately.
